// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Brief    : Shared types and widths for the data-memory responder.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int WORD_W    = 32;
    localparam int LAT_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_wbuf.sv
`default_nettype none
// ============================================================================
// Module   : dmem_wbuf
// Brief    : Single-entry posted write buffer with read forwarding and a
//            drain port into the word array.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_wbuf
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic [WORD_W-1:0] i_load_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic [WORD_W-1:0] i_arr_data,
    output logic [WORD_W-1:0] o_rd_data,
    output logic              o_drain_en,
    output logic [ADDR_W-1:0] o_drain_addr,
    output logic [WORD_W-1:0] o_drain_data
);

    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_data;

    // The entry always drains at the edge after it is loaded, so validity
    // simply tracks whether a new store arrived at this edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_valid <= i_load;
            if (i_load) begin
                r_addr <= i_load_addr;
                r_data <= i_load_data;
            end
        end
    end

    assign o_rd_data    = (r_valid && (r_addr == i_rd_addr)) ? r_data : i_arr_data;
    assign o_drain_en   = r_valid;
    assign o_drain_addr = r_addr;
    assign o_drain_data = r_data;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : MEM-stage data memory with multi-cycle reads (stall request) and
//            posted stores. Optional macro DMEM_ALIGN_CHECK_EN adds
//            misaligned-access detection on output misaligned_m.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int RD_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread_m,
    input  logic        memwrite_m,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        stall_m
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    output logic        misaligned_m
`endif
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [LAT_CNT_W-1:0] c_CNT_INIT =
        (RD_LATENCY > 0) ? LAT_CNT_W'(RD_LATENCY - 1) : '0;

    logic [WORD_W-1:0]    r_mem [DEPTH];
    dmem_state_t          r_state;
    dmem_state_t          w_state_nxt;
    logic [LAT_CNT_W-1:0] r_cnt;
    logic [LAT_CNT_W-1:0] w_cnt_nxt;
    logic [WORD_W-1:0]    r_rdata;
    logic                 w_capture;

    logic [ADDR_W-1:0]    w_idx;
    logic                 w_misaligned;
    logic                 w_idle;
    logic                 w_rd_req;
    logic                 w_st_req;
    logic [WORD_W-1:0]    w_arr_data;
    logic [WORD_W-1:0]    w_fwd_data;
    logic                 w_drain_en;
    logic [ADDR_W-1:0]    w_drain_addr;
    logic [WORD_W-1:0]    w_drain_data;
    logic                 w_unused_addr;

    assign w_idx         = ALUOutM[ADDR_W+1:2];
    assign w_unused_addr = ^{ALUOutM[31:ADDR_W+2], ALUOutM[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_misaligned = (memread_m | memwrite_m) & (ALUOutM[1:0] != 2'b00);
    assign misaligned_m = w_misaligned;
`else
    assign w_misaligned = 1'b0;
`endif

    // Requests are gated by reset so outputs drop immediately on assertion.
    assign w_idle   = reset && (r_state == IDLE);
    assign w_st_req = w_idle && memwrite_m && !w_misaligned;
    assign w_rd_req = w_idle && memread_m && !memwrite_m && !w_misaligned;

    assign w_arr_data = r_mem[w_idx];

    dmem_wbuf #(
        .ADDR_W (ADDR_W)
    ) u_wbuf (
        .i_clk        (clk),
        .i_rst_n      (reset),
        .i_load       (w_st_req),
        .i_load_addr  (w_idx),
        .i_load_data  (WriteDataM),
        .i_rd_addr    (w_idx),
        .i_arr_data   (w_arr_data),
        .o_rd_data    (w_fwd_data),
        .o_drain_en   (w_drain_en),
        .o_drain_addr (w_drain_addr),
        .o_drain_data (w_drain_data)
    );

    always_ff @(posedge clk) begin
        if (w_drain_en) begin
            r_mem[w_drain_addr] <= w_drain_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_capture) begin
                r_rdata <= w_fwd_data;
            end
        end
    end

    // The request cycle itself stalls, so WAIT lasts RD_LATENCY-1 cycles and
    // the total stall equals RD_LATENCY.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        stall_m     = 1'b0;
        ReadDataM   = '0;
        case (r_state)
            IDLE: begin
                if (w_rd_req) begin
                    if (RD_LATENCY == 0) begin
                        ReadDataM = w_fwd_data;
                    end else begin
                        stall_m     = 1'b1;
                        w_capture   = 1'b1;
                        w_cnt_nxt   = c_CNT_INIT;
                        w_state_nxt = (RD_LATENCY == 1) ? DONE : WAIT;
                    end
                end
            end
            WAIT: begin
                stall_m = 1'b1;
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
                if (r_cnt <= LAT_CNT_W'(1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                ReadDataM   = r_rdata;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Randomized self-checking bench for dmem_responder against a
//            word-array reference model (RD_LATENCY=2 and RD_LATENCY=0 units).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        memread_m, memwrite_m;
    logic [31:0] ALUOutM, WriteDataM, ReadDataM;
    logic        stall_m;
    logic        memread_z, memwrite_z;
    logic [31:0] addr_z, wdata_z, rdata_z;
    logic        stall_z;
`ifdef DMEM_ALIGN_CHECK_EN
    logic        misaligned_m, misaligned_z;
`endif

    int n_cmp = 0;
    int n_mis = 0;
    logic [31:0] ref_mem [DEPTH];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .RD_LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset), .memread_m(memread_m), .memwrite_m(memwrite_m),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM), .stall_m(stall_m)
`ifdef DMEM_ALIGN_CHECK_EN
        , .misaligned_m(misaligned_m)
`endif
    );

    dmem_responder #(.DEPTH(DEPTH), .RD_LATENCY(0)) u_dut_l0 (
        .clk(clk), .reset(reset), .memread_m(memread_z), .memwrite_m(memwrite_z),
        .ALUOutM(addr_z), .WriteDataM(wdata_z), .ReadDataM(rdata_z), .stall_m(stall_z)
`ifdef DMEM_ALIGN_CHECK_EN
        , .misaligned_m(misaligned_z)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic bit misal(input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        memread_m  = rd;
        memwrite_m = wr;
        ALUOutM    = a;
        WriteDataM = d;
    endtask

    task automatic op_idle();
        drive(1'b0, 1'b0, $urandom, $urandom);
        @(negedge clk);
        chk("idle_stall", 32'(stall_m), 32'd0);
        chk("idle_rdata", ReadDataM, 32'd0);
    endtask

    // Stores (and read+write collisions) behave as writes: never stall, no data.
    task automatic op_store(input logic rd, input logic [31:0] a, input logic [31:0] d);
        drive(rd, 1'b1, a, d);
        @(negedge clk);
        chk("st_stall", 32'(stall_m), 32'd0);
        chk("st_rdata", ReadDataM, 32'd0);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("st_misal", 32'(misaligned_m), 32'(misal(a)));
`endif
        if (!misal(a)) ref_mem[widx(a)] = d;
    endtask

    task automatic op_read(input logic [31:0] a);
        logic [31:0] exp;
        int exp_lat;
        int n;
        exp     = misal(a) ? 32'd0 : ref_mem[widx(a)];
        exp_lat = misal(a) ? 0 : LAT;
        n = 0;
        drive(1'b1, 1'b0, a, $urandom);
        @(negedge clk);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("rd_misal", 32'(misaligned_m), 32'(misal(a)));
`endif
        while (stall_m === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("rd_stall_cycles", 32'(n), 32'(exp_lat));
        chk("rd_data", ReadDataM, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, d, v1, v2;
        int k;
        reset = 1'b0;
        memread_m = 0; memwrite_m = 0; ALUOutM = 0; WriteDataM = 0;
        memread_z = 0; memwrite_z = 0; addr_z = 0; wdata_z = 0;
        repeat (3) @(negedge clk);
        chk("rst_stall", 32'(stall_m), 32'd0);
        chk("rst_rdata", ReadDataM, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < DEPTH; i++) op_store(1'b0, 32'(i * 4), $urandom);

        // Store then immediate read: forwarded from the buffer.
        op_store(1'b0, 32'h10, 32'hDEADBEEF);
        op_read(32'h10);
        chk("fwd_deadbeef", ReadDataM, 32'hDEADBEEF);

        // Address wrap modulo DEPTH words.
        op_store(1'b0, 32'h0, 32'h11111111);
        op_store(1'b0, 32'h100, 32'h22222222);
        op_idle();
        op_read(32'h0);
        chk("wrap_read", ReadDataM, 32'h22222222);

        op_store(1'b0, 32'h4, 32'hA5A5_0004);
        op_store(1'b0, 32'h8, 32'h5A5A_0008);
        op_read(32'h4);
        op_read(32'h8);

        // Reset while the read is in WAIT.
        drive(1'b1, 1'b0, 32'h20, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_wait_stall", 32'(stall_m), 32'd0);
        chk("rst_wait_rdata", ReadDataM, 32'd0);
        @(negedge clk);
        memread_m = 1'b0;
        reset = 1'b1;

        // Reset with a buffered store still pending: store is lost.
        drive(1'b0, 1'b1, 32'h30, 32'hCAFEF00D);
        @(posedge clk);
        #1;
        memwrite_m = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_wb_stall", 32'(stall_m), 32'd0);
        chk("rst_wb_rdata", ReadDataM, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        op_read(32'h30);

`ifdef DMEM_ALIGN_CHECK_EN
        op_store(1'b0, 32'h6, 32'h66666666);
        op_read(32'h6);
        op_read(32'h4);
`endif

        for (int i = 0; i < 400; i++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a = (a & ~32'h000000FC) | (32'($urandom_range(0, 7)) << 2);
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            d = $urandom;
            k = $urandom_range(0, 9);
            if (k < 4)       op_store(1'b0, a, d);
            else if (k < 8)  op_read(a);
            else if (k == 8) op_store(1'b1, a, d);
            else             op_idle();
        end
        op_idle();

        // Zero-latency unit: data in the request cycle, never a stall.
        v1 = $urandom;
        v2 = $urandom;
        @(posedge clk); #1;
        memwrite_z = 1; addr_z = 32'h4; wdata_z = v1;
        @(negedge clk);
        chk("l0_st_stall", 32'(stall_z), 32'd0);
        @(posedge clk); #1;
        memwrite_z = 0; memread_z = 1;
        @(negedge clk);
        chk("l0_fwd_data", rdata_z, v1);
        chk("l0_fwd_stall", 32'(stall_z), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("l0_arr_data", rdata_z, v1);
        @(posedge clk); #1;
        memread_z = 0; memwrite_z = 1; addr_z = 32'h104; wdata_z = v2;
        @(posedge clk); #1;
        memwrite_z = 0;
        @(posedge clk); #1;
        memread_z = 1; addr_z = 32'h4;
        @(negedge clk);
        chk("l0_wrap_data", rdata_z, v2);
        chk("l0_wrap_stall", 32'(stall_z), 32'd0);
        @(posedge clk); #1;
        memread_z = 0;
        @(negedge clk);
        chk("l0_idle_rdata", rdata_z, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
